sdhci_rx_drain: RTL



---
 rtl/sdhci_rx_drain.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdhci_rx_drain.sv
// SDHC PIO read drain: polls interrupt status, acks Buffer Read Ready per block,
// streams the Buffer Data Port word by word and closes with a Transfer Complete ack.

package sdhci_rx_drain_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;
endpackage

module sdhci_rx_drain #(
   parameter int unsigned          AddrWidth = 32,
   parameter logic [AddrWidth-1:0] BaseAddr  = '0,
   parameter type                  reg_req_t = sdhci_rx_drain_pkg::reg_req_t,
   parameter type                  reg_rsp_t = sdhci_rx_drain_pkg::reg_rsp_t,
   parameter int unsigned          PollGap   = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [11:0] block_size_i,
   input  logic [15:0] block_count_i,
   input  logic        abort_i,
   output reg_req_t    reg_req_o,
   input  reg_rsp_t    reg_rsp_i,
   output logic [31:0] data_o,
   output logic [3:0]  data_strb_o,
   output logic        data_last_o,
   output logic        data_valid_o,
   input  logic        data_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic [3:0]  dbg_state_o
);

   // Handshakes: a bus request is held unchanged from valid=1 until the cycle
   // with ready=1 (rdata/error sampled there), and valid is low the cycle after.
   // A stream word transfers on valid & ready and is held stable until then.

   typedef enum logic [3:0] {
      IDLE, POLL_BRR, GAP_BRR, ACK_BRR, READ, WAIT_OUT,
      POLL_TC, GAP_TC, ACK_TC, ERROR
   } state_e;

   localparam logic [AddrWidth-1:0] AddrData = BaseAddr + AddrWidth'(32'h20);
   localparam logic [AddrWidth-1:0] AddrStat = BaseAddr + AddrWidth'(32'h30);
   localparam int unsigned          GapW     = $clog2(PollGap + 1);

   localparam logic [1:0] CodeBus   = 2'b01;
   localparam logic [1:0] CodeIrq   = 2'b10;
   localparam logic [1:0] CodeAbort = 2'b11;

   state_e          state_q, state_d;
   reg_req_t        req_q, req_d;
   logic [31:0]     data_q, data_d;
   logic [3:0]      strb_q, strb_d;
   logic            last_q, last_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [1:0]      code_q, code_d;
   logic [11:0]     size_q, size_d;
   logic [15:0]     blocks_q, blocks_d;
   logic [9:0]      words_q, words_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic            abort_pend_q, abort_pend_d;

   logic rsp_hs;
   logic abort_now;

   function automatic reg_req_t mk_req(input logic [AddrWidth-1:0] addr,
                                       input logic wr, input logic [31:0] wdata);
      reg_req_t r;
      r       = '0;
      r.addr  = addr;
      r.write = wr;
      r.wdata = wdata;
      r.wstrb = wr ? 4'b0001 : 4'b0000;
      r.valid = 1'b1;
      return r;
   endfunction

   function automatic logic [9:0] words_of(input logic [11:0] s);
      return 10'((13'(s) + 13'd3) >> 2);
   endfunction

   function automatic logic [3:0] tail_strb(input logic [1:0] rem);
      case (rem)
         2'd1:    return 4'b0001;
         2'd2:    return 4'b0011;
         2'd3:    return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      data_d       = data_q;
      strb_d       = strb_q;
      last_d       = last_q;
      valid_d      = valid_q;
      done_d       = 1'b0;
      err_d        = err_q;
      code_d       = code_q;
      size_d       = size_q;
      blocks_d     = blocks_q;
      words_d      = words_q;
      gap_d        = gap_q;
      abort_pend_d = abort_pend_q | (abort_i & (state_q != IDLE));

      rsp_hs    = req_q.valid & reg_rsp_i.ready;
      abort_now = (abort_i | abort_pend_q) & (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (start_i) begin
               err_d        = 1'b0;
               code_d       = 2'b00;
               abort_pend_d = 1'b0;
               size_d       = block_size_i;
               blocks_d     = block_count_i;
               words_d      = words_of(block_size_i);
               if (block_size_i == '0 || block_count_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = POLL_BRR;
                  req_d   = mk_req(AddrStat, 1'b0, 32'h0);
               end
            end
         end

         POLL_BRR, POLL_TC, ACK_BRR, ACK_TC, READ: begin
            if (!req_q.valid) begin
               // Follow-on request after a completed one: issued one cycle late.
               if (abort_now) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  code_d  = CodeAbort;
               end else begin
                  case (state_q)
                     ACK_BRR: req_d = mk_req(AddrStat, 1'b1, 32'h0000_0020);
                     ACK_TC:  req_d = mk_req(AddrStat, 1'b1, 32'h0000_0002);
                     READ:    req_d = mk_req(AddrData, 1'b0, 32'h0);
                     default: req_d = mk_req(AddrStat, 1'b0, 32'h0);
                  endcase
               end
            end else if (rsp_hs) begin
               req_d = '0;
               if (abort_now) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  code_d  = CodeAbort;
               end else if (reg_rsp_i.error) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                  code_d  = CodeBus;
               end else begin
                  case (state_q)
                     POLL_BRR, POLL_TC: begin
                        if (reg_rsp_i.rdata[15]) begin
                           state_d = ERROR;
                           err_d   = 1'b1;
                           code_d  = CodeIrq;
                        end else if (state_q == POLL_BRR && reg_rsp_i.rdata[5]) begin
                           state_d = ACK_BRR;
                        end else if (state_q == POLL_TC && reg_rsp_i.rdata[1]) begin
                           state_d = ACK_TC;
                        end else begin
                           state_d = (state_q == POLL_BRR) ? GAP_BRR : GAP_TC;
                           gap_d   = GapW'(PollGap - 1);
                        end
                     end
                     ACK_BRR: state_d = READ;
                     ACK_TC: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                     default: begin
                        state_d = WAIT_OUT;
                        data_d  = reg_rsp_i.rdata;
                        valid_d = 1'b1;
                        last_d  = (words_q == 10'd1);
                        strb_d  = (words_q == 10'd1) ? tail_strb(size_q[1:0]) : 4'b1111;
                     end
                  endcase
               end
            end
         end

         GAP_BRR, GAP_TC: begin
            if (abort_now) begin
               state_d = ERROR;
               err_d   = 1'b1;
               code_d  = CodeAbort;
            end else if (gap_q == '0) begin
               state_d = (state_q == GAP_BRR) ? POLL_BRR : POLL_TC;
               req_d   = mk_req(AddrStat, 1'b0, 32'h0);
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end

         WAIT_OUT: begin
            if (abort_now) begin
               state_d = ERROR;
               err_d   = 1'b1;
               code_d  = CodeAbort;
               valid_d = 1'b0;
            end else if (data_ready_i) begin
               valid_d = 1'b0;
               if (words_q == 10'd1) begin
                  words_d = words_of(size_q);
                  if (blocks_q == 16'd1) begin
                     state_d = POLL_TC;
                  end else begin
                     state_d  = POLL_BRR;
                     blocks_d = blocks_q - 1'b1;
                  end
                  req_d = mk_req(AddrStat, 1'b0, 32'h0);
               end else begin
                  state_d = READ;
                  words_d = words_q - 1'b1;
                  req_d   = mk_req(AddrData, 1'b0, 32'h0);
               end
            end
         end

         ERROR: begin
            state_d      = IDLE;
            abort_pend_d = 1'b0;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         req_q        <= '0;
         data_q       <= '0;
         strb_q       <= '0;
         last_q       <= 1'b0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         code_q       <= 2'b00;
         size_q       <= '0;
         blocks_q     <= '0;
         words_q      <= '0;
         gap_q        <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         data_q       <= data_d;
         strb_q       <= strb_d;
         last_q       <= last_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
         code_q       <= code_d;
         size_q       <= size_d;
         blocks_q     <= blocks_d;
         words_q      <= words_d;
         gap_q        <= gap_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   assign reg_req_o    = req_q;
   assign data_o       = data_q;
   assign data_strb_o  = strb_q;
   assign data_last_o  = last_q;
   assign data_valid_o = valid_q;
   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign err_code_o   = code_q;
   assign dbg_state_o  = state_q;

endmodule
